// File: rtl/worley_pkg.sv
// Shared constants, FSM state type and reset tables for the Worley point animator.
// Point i lives at bits [W*i +: W] of every packed table.
package worley_pkg;

    localparam int NUM_POINTS = 4;
    localparam int COORD_W    = 10;
    localparam int VEL_W      = 4;
    localparam int TIME_W     = 20;
    localparam int IDX_W      = $clog2(NUM_POINTS);
    localparam int SUM_W      = COORD_W + 2;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_UPDATE = 2'd1,
        ST_COMMIT = 2'd2
    } state_t;

    localparam logic [NUM_POINTS*COORD_W-1:0] RST_X  = {10'd100, 10'd500, 10'd300, 10'd100};
    localparam logic [NUM_POINTS*COORD_W-1:0] RST_Y  = {10'd460, 10'd400, 10'd200, 10'd100};
    localparam logic [NUM_POINTS*VEL_W-1:0]   RST_VX = {4'hF, 4'h2, 4'hF, 4'h1};
    localparam logic [NUM_POINTS*VEL_W-1:0]   RST_VY = {4'hE, 4'hF, 4'h1, 4'hF};

endpackage

// File: rtl/worley_point_animator_if.sv
// Frame-tick request side and published point/status side of the animator.
interface worley_point_animator_if;
    import worley_pkg::*;

    logic                           frame_tick;
    logic                           freeze;
    logic [NUM_POINTS*COORD_W-1:0]  pts_x;
    logic [NUM_POINTS*COORD_W-1:0]  pts_y;
    logic [TIME_W-1:0]              frame_count;
    logic                           busy;
    logic                           tick_dropped;

    modport master (
        output frame_tick, freeze,
        input  pts_x, pts_y, frame_count, busy, tick_dropped
    );

    modport slave (
        input  frame_tick, freeze,
        output pts_x, pts_y, frame_count, busy, tick_dropped
    );

endinterface

// File: rtl/worley_axis_step.sv
// One-axis move with mirror reflection at 0 and at i_max.
// JITTER_EN replaces the reflected speed with 1 + i_jit (sign still reversed).
module worley_axis_step
    import worley_pkg::*;
#(
    parameter bit JITTER_EN = 1'b0
) (
    input  logic [COORD_W-1:0]       i_pos,
    input  logic signed [VEL_W-1:0]  i_vel,
    input  logic [COORD_W-1:0]       i_max,
    input  logic [1:0]               i_jit,
    output logic [COORD_W-1:0]       o_pos,
    output logic signed [VEL_W-1:0]  o_vel
);

    logic signed [SUM_W-1:0] w_vel_ext;
    logic signed [SUM_W-1:0] w_n;
    logic signed [SUM_W-1:0] w_max_s;
    logic signed [SUM_W-1:0] w_refl_hi;
    logic [VEL_W-1:0]        w_mag;
    logic signed [VEL_W-1:0] w_vel_refl;

    assign w_vel_ext  = {{(SUM_W-VEL_W){i_vel[VEL_W-1]}}, i_vel};
    assign w_n        = $signed({{(SUM_W-COORD_W){1'b0}}, i_pos}) + w_vel_ext;
    assign w_max_s    = $signed({{(SUM_W-COORD_W){1'b0}}, i_max});
    assign w_refl_hi  = w_max_s + w_max_s - w_n;
    assign w_mag      = VEL_W'(i_jit) + VEL_W'(1);
    // A negative incoming velocity reflects to a positive one and vice versa.
    assign w_vel_refl = JITTER_EN ? (i_vel[VEL_W-1] ? w_mag : -w_mag) : -i_vel;

    always_comb begin
        o_pos = COORD_W'(w_n);
        o_vel = i_vel;
        if (w_n < 0) begin
            o_pos = COORD_W'(-w_n);
            o_vel = w_vel_refl;
        end else if (w_n > w_max_s) begin
            o_pos = COORD_W'(w_refl_hi);
            o_vel = w_vel_refl;
        end
    end

endmodule

// File: rtl/worley_point_animator.sv
// Bouncing feature points for a Worley noise field: one point stepped per cycle, all published at once.
// Define WORLEY_POINT_JITTER_EN to randomise the speed after each wall reflection.
module worley_point_animator
    import worley_pkg::*;
#(
    parameter int H_ACTIVE = 640,
    parameter int V_ACTIVE = 480
) (
    input  logic                    clk,
    input  logic                    rst_n,
    worley_point_animator_if.slave  bus
);

    localparam logic [COORD_W-1:0] X_MAX = COORD_W'(H_ACTIVE - 1);
    localparam logic [COORD_W-1:0] Y_MAX = COORD_W'(V_ACTIVE - 1);
`ifdef WORLEY_POINT_JITTER_EN
    localparam bit JIT_EN = 1'b1;
`else
    localparam bit JIT_EN = 1'b0;
`endif

    state_t                         r_state, w_state_next;
    logic [IDX_W-1:0]               r_idx;
    logic                           w_busy, w_update, w_commit;
    logic [NUM_POINTS*COORD_W-1:0]  w_work_x, w_work_y, r_pts_x, r_pts_y;
    logic [NUM_POINTS*VEL_W-1:0]    w_work_vx, w_work_vy;
    logic [COORD_W-1:0]             w_cur_x, w_cur_y, w_new_x, w_new_y;
    logic signed [VEL_W-1:0]        w_cur_vx, w_cur_vy, w_new_vx, w_new_vy;
    logic [TIME_W-1:0]              r_frame_count;
    logic                           r_tick_dropped;
    logic [1:0]                     w_jit;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
            r_idx   <= '0;
        end else begin
            r_state <= w_state_next;
            r_idx   <= (r_state == ST_UPDATE) ? r_idx + 1'b1 : '0;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (bus.frame_tick && !bus.freeze) w_state_next = ST_UPDATE;
            ST_UPDATE: if (r_idx == IDX_W'(NUM_POINTS - 1)) w_state_next = ST_COMMIT;
            ST_COMMIT: w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_busy   = (r_state != ST_IDLE);
        w_update = (r_state == ST_UPDATE);
        w_commit = (r_state == ST_COMMIT);
    end

`ifdef WORLEY_POINT_JITTER_EN
    logic [15:0] r_lfsr;
    always_ff @(posedge clk) begin
        if (!rst_n) r_lfsr <= 16'hACE1;
        else        r_lfsr <= {r_lfsr[14:0], r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10]};
    end
    assign w_jit = r_lfsr[1:0];
`else
    assign w_jit = 2'b00;
`endif

    // Working set: only the point selected by r_idx moves in a given UPDATE cycle.
    for (genvar gi = 0; gi < NUM_POINTS; gi++) begin : g_pt
        logic [COORD_W-1:0] r_x, r_y;
        logic [VEL_W-1:0]   r_vx, r_vy;

        always_ff @(posedge clk) begin
            if (!rst_n) begin
                r_x  <= RST_X[gi*COORD_W +: COORD_W];
                r_y  <= RST_Y[gi*COORD_W +: COORD_W];
                r_vx <= RST_VX[gi*VEL_W +: VEL_W];
                r_vy <= RST_VY[gi*VEL_W +: VEL_W];
            end else if (w_update && r_idx == IDX_W'(gi)) begin
                r_x  <= w_new_x;
                r_y  <= w_new_y;
                r_vx <= w_new_vx;
                r_vy <= w_new_vy;
            end
        end

        assign w_work_x[gi*COORD_W +: COORD_W] = r_x;
        assign w_work_y[gi*COORD_W +: COORD_W] = r_y;
        assign w_work_vx[gi*VEL_W +: VEL_W]    = r_vx;
        assign w_work_vy[gi*VEL_W +: VEL_W]    = r_vy;
    end

    assign w_cur_x  = w_work_x[r_idx*COORD_W +: COORD_W];
    assign w_cur_y  = w_work_y[r_idx*COORD_W +: COORD_W];
    assign w_cur_vx = $signed(w_work_vx[r_idx*VEL_W +: VEL_W]);
    assign w_cur_vy = $signed(w_work_vy[r_idx*VEL_W +: VEL_W]);

    worley_axis_step #(.JITTER_EN(JIT_EN)) u_step_x (
        .i_pos(w_cur_x), .i_vel(w_cur_vx), .i_max(X_MAX), .i_jit(w_jit),
        .o_pos(w_new_x), .o_vel(w_new_vx)
    );

    worley_axis_step #(.JITTER_EN(JIT_EN)) u_step_y (
        .i_pos(w_cur_y), .i_vel(w_cur_vy), .i_max(Y_MAX), .i_jit(w_jit),
        .o_pos(w_new_y), .o_vel(w_new_vy)
    );

    // Published points change only here, so consumers never see a half-updated frame.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pts_x        <= RST_X;
            r_pts_y        <= RST_Y;
            r_frame_count  <= '0;
            r_tick_dropped <= 1'b0;
        end else begin
            if (w_commit) begin
                r_pts_x       <= w_work_x;
                r_pts_y       <= w_work_y;
                r_frame_count <= r_frame_count + TIME_W'(1);
            end
            if (w_busy && bus.frame_tick) r_tick_dropped <= 1'b1;
        end
    end

    assign bus.pts_x        = r_pts_x;
    assign bus.pts_y        = r_pts_y;
    assign bus.frame_count  = r_frame_count;
    assign bus.busy         = w_busy;
    assign bus.tick_dropped = r_tick_dropped;

endmodule

// File: tb/tb_worley_point_animator.sv
// Self-checking bench: hand-computed frame table, reference-model scoreboard, wall/drop/reset sequences.
// With WORLEY_POINT_JITTER_EN defined only range and frame-count properties are checked.
module tb_worley_point_animator;

    localparam int XM = 639;
    localparam int YM = 479;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    worley_point_animator_if bus();

    worley_point_animator #(.H_ACTIVE(640), .V_ACTIVE(480)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus)
    );

    typedef struct {
        bit          freeze;
        int          exp_fc;
        logic [39:0] exp_x;
        logic [39:0] exp_y;
    } vec_t;

    typedef struct {
        int          fc;
        logic [39:0] x;
        logic [39:0] y;
    } exp_t;

    vec_t tbl[4];
    exp_t sbq[$];
    int   total = 0;
    int   bad   = 0;
    int   mx[4], my[4], mvx[4], mvy[4];
    int   mfc;

    function automatic logic [39:0] pack4(input int a0, input int a1, input int a2, input int a3);
        return {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s actual=%0d required=%0d", name, act, exp);
        end
    endtask

    task automatic model_reset();
        mx  = '{100, 300, 500, 100};
        my  = '{100, 200, 400, 460};
        mvx = '{1, -1, 2, -1};
        mvy = '{-1, 1, -1, -2};
        mfc = 0;
    endtask

    task automatic model_tick();
        int n;
        for (int i = 0; i < 4; i++) begin
            n = mx[i] + mvx[i];
            if (n < 0)       begin mx[i] = -n;         mvx[i] = -mvx[i]; end
            else if (n > XM) begin mx[i] = 2 * XM - n; mvx[i] = -mvx[i]; end
            else             mx[i] = n;
            n = my[i] + mvy[i];
            if (n < 0)       begin my[i] = -n;         mvy[i] = -mvy[i]; end
            else if (n > YM) begin my[i] = 2 * YM - n; mvy[i] = -mvy[i]; end
            else             my[i] = n;
        end
        mfc = (mfc + 1) % (1 << 20);
    endtask

    task automatic push_expect();
        exp_t e;
        e.fc = mfc;
        e.x  = pack4(mx[0], mx[1], mx[2], mx[3]);
        e.y  = pack4(my[0], my[1], my[2], my[3]);
        sbq.push_back(e);
    endtask

    task automatic pop_compare(input string tag);
        exp_t e;
        if (sbq.size() == 0) begin
            total++; bad++;
            $display("FAIL %s_sb_empty actual=0 required=1", tag);
        end else begin
            e = sbq.pop_front();
            $display("txn %s fc=%0d pts_x=%h pts_y=%h", tag, bus.frame_count, bus.pts_x, bus.pts_y);
            check({tag, "_fc"}, bus.frame_count, e.fc);
            check({tag, "_x"},  bus.pts_x, e.x);
            check({tag, "_y"},  bus.pts_y, e.y);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        bus.frame_tick = 1'b0;
        bus.freeze = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        model_reset();
        sbq.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_rst_x"},   bus.pts_x, pack4(100, 300, 500, 100));
        check({tag, "_rst_y"},   bus.pts_y, pack4(100, 200, 400, 460));
        check({tag, "_rst_fc"},  bus.frame_count, 0);
        check({tag, "_rst_busy"}, bus.busy, 0);
        check({tag, "_rst_drop"}, bus.tick_dropped, 0);
    endtask

    // Leaves the caller 1 ns after the edge that sampled the tick.
    task automatic pulse_tick(input bit fr);
        @(posedge clk); #1;
        bus.frame_tick = 1'b1;
        bus.freeze = fr;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        bus.freeze = 1'b0;
    endtask

    task automatic wait_idle(input string tag);
        bit ok = 1'b0;
        for (int k = 0; k < 20 && !ok; k++) begin
            @(negedge clk);
            if (!bus.busy) ok = 1'b1;
        end
        if (!ok) begin
            total++; bad++;
            $display("FAIL %s_timeout actual=busy required=idle", tag);
        end
    endtask

    task automatic run_tick(input string tag);
        model_tick();
        push_expect();
        pulse_tick(1'b0);
        wait_idle(tag);
        pop_compare(tag);
    endtask

`ifdef WORLEY_POINT_JITTER_EN
    int range_bad = 0;
    bit mon_en = 1'b0;
    always @(negedge clk) begin
        if (mon_en) begin
            for (int i = 0; i < 4; i++) begin
                if (bus.pts_x[i*10 +: 10] > 10'(XM) || bus.pts_y[i*10 +: 10] > 10'(YM)) range_bad++;
            end
        end
    end
`endif

    initial begin
        #1_000_000;
        $display("FAIL watchdog actual=running required=finished");
        $fatal(1, "watchdog expired");
    end

    initial begin
        tbl[0] = '{1'b0, 1, pack4(101, 299, 502, 99), pack4(99, 201, 399, 458)};
        tbl[1] = '{1'b1, 1, pack4(101, 299, 502, 99), pack4(99, 201, 399, 458)};
        tbl[2] = '{1'b0, 2, pack4(102, 298, 504, 98), pack4(98, 202, 398, 456)};
        tbl[3] = '{1'b0, 3, pack4(103, 297, 506, 97), pack4(97, 203, 397, 454)};

        do_reset();
        @(negedge clk);
        check_reset_outputs("init");

`ifdef WORLEY_POINT_JITTER_EN
        mon_en = 1'b1;
        for (int t = 1; t <= 2000; t++) begin
            pulse_tick(1'b0);
            wait_idle("jit");
            check($sformatf("jit_fc_%0d", t), bus.frame_count, t);
        end
        check("jit_range", range_bad, 0);
        check("jit_fc_final", bus.frame_count, 2000);
`else
        // Table frames: exact five-cycle busy window, then the new frame in the sixth.
        for (int t = 0; t < 4; t++) begin
            if (!tbl[t].freeze) model_tick();
            push_expect();
            pulse_tick(tbl[t].freeze);
            for (int k = 1; k <= 5; k++) begin
                @(negedge clk);
                check($sformatf("tbl%0d_busy_c%0d", t, k), bus.busy, !tbl[t].freeze);
            end
            @(negedge clk);
            check($sformatf("tbl%0d_busy_c6", t), bus.busy, 0);
            pop_compare($sformatf("tbl%0d", t));
            check($sformatf("tbl%0d_fc_const", t), bus.frame_count, tbl[t].exp_fc);
            check($sformatf("tbl%0d_x_const", t), bus.pts_x, tbl[t].exp_x);
            check($sformatf("tbl%0d_y_const", t), bus.pts_y, tbl[t].exp_y);
        end

        // Walk until P2 hits the right wall and P0 hits the top wall.
        while (mfc < 102) begin
            run_tick($sformatf("walk%0d", mfc + 1));
            if (mfc == 69)  check("p2_x_at_638", bus.pts_x[29:20], 638);
            if (mfc == 70)  check("p2_x_reflect", bus.pts_x[29:20], 638);
            if (mfc == 71)  check("p2_x_after", bus.pts_x[29:20], 636);
            if (mfc == 100) check("p0_y_at_0", bus.pts_y[9:0], 0);
            if (mfc == 101) check("p0_y_reflect", bus.pts_y[9:0], 1);
            if (mfc == 102) check("p0_y_after", bus.pts_y[9:0], 2);
        end

        // Freeze raised mid-update must not abort the frame.
        model_tick();
        push_expect();
        pulse_tick(1'b0);
        bus.freeze = 1'b1;
        wait_idle("freeze_busy");
        bus.freeze = 1'b0;
        pop_compare("freeze_busy");

        // Second tick three cycles into an update is dropped and flagged.
        do_reset();
        model_tick();
        push_expect();
        pulse_tick(1'b0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        bus.frame_tick = 1'b1;
        @(posedge clk); #1;
        bus.frame_tick = 1'b0;
        wait_idle("drop");
        pop_compare("drop");
        check("drop_flag", bus.tick_dropped, 1);
        repeat (10) @(negedge clk);
        check("drop_fc_hold", bus.frame_count, 1);
        check("drop_busy_hold", bus.busy, 0);
        check("drop_flag_sticky", bus.tick_dropped, 1);

        // Reset in the middle of an update restores everything, including working state.
        pulse_tick(1'b0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        model_reset();
        sbq.delete();
        @(negedge clk);
        check_reset_outputs("midrst");
        run_tick("post_midrst");
        check("post_midrst_p0x", bus.pts_x[9:0], 101);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
